// File: rtl/control_fsm.sv
// Multicycle controller: sequences fetch/decode/execute/memory/writeback and owns PC update.
// Latency: R/I 4, LW 5, SW 4, BEQ 3 cycles at zero wait; each memory wait cycle adds one.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR until ready; optional timeout parks the core in HALT.
module control_fsm #(
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             reg_write,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             result_src,
  output logic             halt,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [1:0] PC_4      = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Timeout compare point: the last allowed wait cycle is MEM_TIMEOUT-1 counted from zero.
  localparam int              WAIT_W    = 32;
  localparam bit              TO_EN     = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = TO_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_HALT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_timeout_err;
  logic [CNT_W-1:0]   r_instr_count;
  logic               w_wait_expired;
  logic               w_set_timeout;
  logic               w_enter_wait;
  logic               w_waiting;

  // Expiry only matters while a handshake is pending; a same-cycle ready takes priority below.
  assign w_wait_expired = TO_EN && (r_wait_cnt == WAIT_LAST);

  // Counter restarts whenever a new handshake state is entered (including MEM_WR -> FETCH).
  assign w_enter_wait = (w_next != r_state) &&
                        ((w_next == S_FETCH) || (w_next == S_MEM_RD) || (w_next == S_MEM_WR));
  assign w_waiting    = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);

  assign timeout_err = r_timeout_err;
  assign instr_count = r_instr_count;

  // State, wait counter, sticky timeout flag and retired-instruction counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_enter_wait) begin
        r_wait_cnt <= '0;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (w_set_timeout) begin
        r_timeout_err <= 1'b1;
      end
      if (pc_write) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  // Next-state and Moore outputs; ir_write and the MEM_WR pc_write follow the ready input.
  always_comb begin
    w_next        = r_state;
    w_set_timeout = 1'b0;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = PC_4;
    reg_write     = 1'b0;
    alu_src_b     = 1'b0;
    alu_op        = ALU_ADD;
    result_src    = 1'b0;
    halt          = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_wait_expired) begin
          w_set_timeout = 1'b1;
          w_next        = S_HALT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               w_next = S_EXEC_R;
          OP_I:               w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
          OP_BRANCH:          w_next = (funct3 == F3_BEQ) ? S_BRANCH : S_HALT;
          default:            w_next = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        alu_src_b = 1'b0;
        alu_op    = ALU_FUNCT;
        w_next    = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = ALU_FUNCT;
        w_next    = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_b = 1'b1;
        alu_op    = ALU_ADD;
        // Instruction register is stable for the whole instruction, so re-check the opcode here.
        w_next    = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b0;
        if (dmem_ready) begin
          w_next = S_WB_MEM;
        end else if (w_wait_expired) begin
          w_set_timeout = 1'b1;
          w_next        = S_HALT;
        end
      end
      S_MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (dmem_ready) begin
          pc_write = 1'b1;
          pc_sel   = PC_4;
          w_next   = S_FETCH;
        end else if (w_wait_expired) begin
          w_set_timeout = 1'b1;
          w_next        = S_HALT;
        end
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        result_src = 1'b0;
        pc_write   = 1'b1;
        pc_sel     = PC_4;
        w_next     = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 1'b1;
        pc_write   = 1'b1;
        pc_sel     = PC_4;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b = 1'b0;
        alu_op    = ALU_SUB;
        pc_write  = 1'b1;
        pc_sel    = PC_BRANCH;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: random instruction mix against a per-instruction summary model.
// Main instance waits forever; second instance has a 4-cycle timeout and a 3-bit counter.
// Ready inputs are driven from observed requests with random wait counts and random noise.
module tb_control_fsm;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;

  logic        clk = 1'b0;
  logic        arst_n;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        imem_ready, dmem_ready;
  logic        imem_req, ir_write, dmem_req, dmem_we, pc_write;
  logic [1:0]  pc_sel, alu_op;
  logic        reg_write, alu_src_b, result_src, halt, timeout_err;
  logic [31:0] instr_count;

  logic [6:0]  t_opcode;
  logic [2:0]  t_funct3;
  logic        t_imem_ready, t_dmem_ready;
  logic        t_imem_req, t_ir_write, t_dmem_req, t_dmem_we, t_pc_write;
  logic [1:0]  t_pc_sel, t_alu_op;
  logic        t_reg_write, t_alu_src_b, t_result_src, t_halt, t_timeout_err;
  logic [2:0]  t_instr_count;

  logic [13:0] w_outs, t_outs;
  assign w_outs = {imem_req, ir_write, dmem_req, dmem_we, pc_write, pc_sel,
                   reg_write, alu_src_b, alu_op, result_src, halt, timeout_err};
  assign t_outs = {t_imem_req, t_ir_write, t_dmem_req, t_dmem_we, t_pc_write, t_pc_sel,
                   t_reg_write, t_alu_src_b, t_alu_op, t_result_src, t_halt, t_timeout_err};

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  control_fsm #(.MEM_TIMEOUT(0), .CNT_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .opcode(opcode), .funct3(funct3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .halt(halt), .timeout_err(timeout_err),
    .instr_count(instr_count)
  );

  control_fsm #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_to (
    .clk(clk), .arst_n(arst_n), .opcode(t_opcode), .funct3(t_funct3),
    .imem_ready(t_imem_ready), .dmem_ready(t_dmem_ready),
    .imem_req(t_imem_req), .ir_write(t_ir_write), .dmem_req(t_dmem_req), .dmem_we(t_dmem_we),
    .pc_write(t_pc_write), .pc_sel(t_pc_sel), .reg_write(t_reg_write), .alu_src_b(t_alu_src_b),
    .alu_op(t_alu_op), .result_src(t_result_src), .halt(t_halt), .timeout_err(t_timeout_err),
    .instr_count(t_instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rules: cycle counts and which instruction classes touch which controls.
  function automatic int base_cycles(input int kind);
    case (kind)
      K_LW:    return 5;
      K_BEQ:   return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [6:0] opc_of(input int kind);
    case (kind)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      default: return 7'b1100011;
    endcase
  endfunction

  task automatic reset_pulse();
    @(negedge clk);
    arst_n = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    t_imem_ready = 1'b1; t_dmem_ready = 1'b1;
    #1;
    chk("reset_outputs_immediate", 32'(w_outs), 0);
    chk("reset_t_outputs", 32'(t_outs), 0);
    @(negedge clk);
    #1;
    chk("reset_outputs_held", 32'(w_outs), 0);
    chk("reset_count", instr_count, 0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("idle_outputs", 32'(w_outs), 0);
    exp_cnt = 0;
  endtask

  task automatic run_instr(input int kind, input int wf, input int wd);
    int  n_i, n_d, n_irw, n_pcw, n_rw, n_op10, n_op01, n_srcb, bad_we, bad_rs, done_cyc, budget;
    logic sel_at, rw_at, dhs_at;
    logic is_ld, is_st, is_mem, wr_reg;
    is_ld  = (kind == K_LW);
    is_st  = (kind == K_SW);
    is_mem = is_ld || is_st;
    wr_reg = (kind == K_R) || (kind == K_I) || (kind == K_LW);
    opcode = opc_of(kind);
    funct3 = (kind == K_BEQ) ? 3'b000 : 3'($urandom_range(0, 7));
    n_i = 0; n_d = 0; n_irw = 0; n_pcw = 0; n_rw = 0; n_op10 = 0; n_op01 = 0; n_srcb = 0;
    bad_we = 0; bad_rs = 0; done_cyc = 0;
    sel_at = 1'b0; rw_at = 1'b0; dhs_at = 1'b0;
    budget = base_cycles(kind) + wf + wd + 6;
    for (int c = 1; c <= budget && done_cyc == 0; c++) begin
      @(negedge clk);
      imem_ready = imem_req ? (n_i == wf) : 1'($urandom_range(0, 1));
      dmem_ready = dmem_req ? (n_d == wd) : 1'($urandom_range(0, 1));
      #1;
      if (imem_req) n_i++;
      if (ir_write) n_irw++;
      if (dmem_req) begin
        n_d++;
        if (dmem_we !== is_st) bad_we++;
      end
      if (reg_write) begin
        n_rw++;
        if (result_src !== is_ld) bad_rs++;
      end
      if (alu_op == 2'b10) n_op10++;
      if (alu_op == 2'b01) n_op01++;
      if (alu_src_b) n_srcb++;
      if (pc_write) begin
        n_pcw++;
        sel_at   = pc_sel[0] | pc_sel[1];
        rw_at    = reg_write;
        dhs_at   = dmem_req & dmem_ready;
        done_cyc = c;
      end
    end
    @(posedge clk);
    #1;
    exp_cnt++;
    chk("cycles", done_cyc, base_cycles(kind) + wf + (is_mem ? wd : 0));
    chk("pc_write_pulses", n_pcw, 1);
    chk("imem_req_cycles", n_i, wf + 1);
    chk("ir_write_cycles", n_irw, 1);
    chk("dmem_req_cycles", n_d, is_mem ? wd + 1 : 0);
    chk("dmem_we_bad", bad_we, 0);
    chk("reg_write_cycles", n_rw, wr_reg ? 1 : 0);
    chk("result_src_bad", bad_rs, 0);
    chk("pc_sel_branch", sel_at, kind == K_BEQ);
    chk("reg_write_with_pcw", rw_at, wr_reg);
    chk("sw_ready_with_pcw", dhs_at, is_st);
    chk("alu_op_funct_cycles", n_op10, (kind == K_R || kind == K_I) ? 1 : 0);
    chk("alu_op_sub_cycles", n_op01, kind == K_BEQ);
    chk("alu_src_b_imm_cycles", n_srcb, (kind == K_I || is_mem) ? 1 : 0);
    chk("instr_count", instr_count, exp_cnt);
  endtask

  task automatic run_illegal(input logic [6:0] opc, input logic [2:0] f3, input int wf);
    int n_i, n_pcw, halt_cyc;
    opcode = opc; funct3 = f3;
    n_i = 0; n_pcw = 0; halt_cyc = 0;
    for (int c = 1; c <= wf + 8 && halt_cyc == 0; c++) begin
      @(negedge clk);
      imem_ready = imem_req ? (n_i == wf) : 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      if (imem_req) n_i++;
      if (pc_write) n_pcw++;
      if (halt) halt_cyc = c;
    end
    chk("halt_cycle", halt_cyc, wf + 3);
    chk("halt_imem_cycles", n_i, wf + 1);
    chk("halt_no_pcw", n_pcw, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      imem_ready = 1'b1; dmem_ready = 1'b1;
      #1;
      chk("halt_outputs", 32'(w_outs), 32'h2);
    end
    chk("halt_count_frozen", instr_count, exp_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    arst_n = 1'b1;
    opcode = 7'b0110011; funct3 = 3'b000; imem_ready = 1'b0; dmem_ready = 1'b0;
    t_opcode = 7'b0110011; t_funct3 = 3'b000; t_imem_ready = 1'b0; t_dmem_ready = 1'b0;

    reset_pulse();

    // Back-to-back R-type at zero wait, then directed memory/branch cases.
    run_instr(K_R, 0, 0);
    run_instr(K_R, 0, 0);
    run_instr(K_R, 0, 0);
    run_instr(K_LW, 0, 3);
    run_instr(K_BEQ, 0, 0);
    run_instr(K_SW, 0, 0);
    run_instr(K_SW, 2, 2);
    run_instr(K_I, 1, 0);
    run_instr(K_LW, 6, 0);

    for (int n = 0; n < 40; n++) begin
      run_instr($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 6));
    end

    // ECALL parks the core; reset restarts it from IDLE.
    run_illegal(7'b1110011, 3'b000, 1);
    reset_pulse();
    run_instr(K_R, 0, 0);
    // BNE is unsupported.
    run_illegal(7'b1100011, 3'b001, 0);

    // Reset while a fetch is stalled drops the request at once.
    reset_pulse();
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("stalled_fetch_req", imem_req, 1);
    reset_pulse();

    // Timeout instance: imem_ready held low through four wait cycles.
    t_imem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      if (k == 4) chk("to_fetch_4th_cycle", {t_imem_req, t_halt}, 2'b10);
    end
    @(negedge clk);
    #1;
    chk("to_halt", {t_halt, t_timeout_err, t_imem_req}, 3'b110);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      t_imem_ready = 1'b1;
      #1;
      chk("to_halt_sticky", 32'(t_outs), 32'h3);
    end

    // Ready on the fourth wait cycle completes normally.
    reset_pulse();
    t_imem_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      t_imem_ready = (k == 4);
      #1;
      if (k == 4) chk("to_ready_4th_ir_write", t_ir_write, 1);
      if (k == 5) chk("to_ready_4th_no_err", {t_halt, t_timeout_err}, 2'b00);
      if (k == 7) chk("to_ready_4th_retire", t_pc_write, 1);
      if (k == 8) chk("to_ready_4th_count", t_instr_count, 1);
    end

    // 3-bit counter wraps after eight retirements.
    reset_pulse();
    t_imem_ready = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      #1;
      if (t_pc_write) pulses++;
    end
    @(negedge clk);
    #1;
    chk("wrap_pulses", pulses, 9);
    chk("wrap_count", t_instr_count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
